// File: rtl/pipelined_skip_sub_pkg.sv
// Shared definitions for the pipelined carry-skip subtractor: default
// geometry, the slice-width helper and the per-stage pipeline record.
// The record is sized by DEF_WIDTH, so a different WIDTH is built by
// changing the defaults here rather than only overriding the top parameter.
package pipelined_skip_sub_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // Width of one carry-skip slice; one slice is evaluated per stage.
    function automatic int block_width(input int width, input int stages);
        return width / stages;
    endfunction

    // One pipeline stage: operands ride along in full so later stages can
    // pick their slice, and the result accumulates from the bottom up.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] a_rem;
        logic [DEF_WIDTH-1:0] b_rem;
        logic [DEF_WIDTH-1:0] diff_acc;
        logic                 zero_acc;
    } stage_t;

endpackage

// File: rtl/pipelined_skip_subtractor_if.sv
// Operand/result handshake bundle for pipelined_skip_subtractor.
// Optional zero/neg flags appear when PIPELINED_SKIP_SUB_FLAGS_EN is defined.
interface pipelined_skip_subtractor_if
    import pipelined_skip_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
    logic             zero;
    logic             neg;
`endif

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
        , input zero, neg
`endif
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
        , output zero, neg
`endif
    );

endinterface

// File: rtl/pipelined_skip_subtractor_slice.sv
// One BLOCK-bit carry-skip slice computing a + ~b + cin.
// When every bit propagates, cout is taken straight from cin (skip path).
module skip_sub_slice #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] d,
    output logic             cout,
    output logic             c_msb_in,
    output logic             all_p
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   c;

    // Ripple carries plus the skip mux on the slice carry-out.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here first thing), otherwise synthesis infers a latch.
        p = a ^ ~b;
        g = a & ~b;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        d        = p ^ c[BLOCK-1:0];
        all_p    = &p;
        cout     = all_p ? cin : c[BLOCK];
        c_msb_in = c[BLOCK-1];
    end

endmodule

// File: rtl/pipelined_skip_subtractor.sv
// Pipelined WIDTH-bit subtractor, diff = a - b - bin, one carry-skip slice
// per stage with operand skew and valid/ready on both sides.
// Optional flags: define PIPELINED_SKIP_SUB_FLAGS_EN for zero/neg outputs.
module pipelined_skip_subtractor
    import pipelined_skip_sub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input logic                        clk,
    input logic                        rst,
    pipelined_skip_subtractor_if.slave bus
);

    localparam int BLOCK = block_width(WIDTH, STAGES);

    stage_t [STAGES-1:0]            stage_q;
    stage_t [STAGES-1:0]            stage_d;
    logic                           bout_q;
    logic                           bout_d;
    logic                           ovf_q;
    logic                           ovf_d;
    logic [STAGES-1:0][BLOCK-1:0]   d_w;
    logic [STAGES-1:0]              cout_w;
    logic [STAGES-1:0]              c_msb_w;
    logic [STAGES-1:0]              all_p_w;
    logic                           stall;
    logic                           unused_bits;

    // A held result freezes the whole pipe; otherwise everything shifts.
    assign stall = stage_q[STAGES-1].valid & ~bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [BLOCK-1:0] a_sl;
        logic [BLOCK-1:0] b_sl;
        logic             cin_sl;

        if (k == 0) begin : g_first
            assign a_sl   = bus.a[BLOCK-1:0];
            assign b_sl   = bus.b[BLOCK-1:0];
            assign cin_sl = ~bus.bin;
        end else begin : g_rest
            assign a_sl   = stage_q[k-1].a_rem[k*BLOCK +: BLOCK];
            assign b_sl   = stage_q[k-1].b_rem[k*BLOCK +: BLOCK];
            assign cin_sl = stage_q[k-1].carry;
        end

        skip_sub_slice #(.BLOCK(BLOCK)) u_slice (
            .a        (a_sl),
            .b        (b_sl),
            .cin      (cin_sl),
            .d        (d_w[k]),
            .cout     (cout_w[k]),
            .c_msb_in (c_msb_w[k]),
            .all_p    (all_p_w[k])
        );
    end

    // Next stage contents: load stage 0 from the bus, shift the rest down.
    always_comb begin
        stage_d = stage_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        if (!stall) begin
            stage_d[0].valid               = bus.in_valid;
            stage_d[0].carry               = cout_w[0];
            stage_d[0].a_rem               = bus.a;
            stage_d[0].b_rem               = bus.b;
            stage_d[0].diff_acc            = '0;
            stage_d[0].diff_acc[BLOCK-1:0] = d_w[0];
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
            stage_d[0].zero_acc            = ~|d_w[0];
`else
            stage_d[0].zero_acc            = 1'b0;
`endif
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k]                             = stage_q[k-1];
                stage_d[k].carry                       = cout_w[k];
                stage_d[k].diff_acc[k*BLOCK +: BLOCK]  = d_w[k];
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
                stage_d[k].zero_acc = stage_q[k-1].zero_acc & ~|d_w[k];
`endif
            end
            bout_d = ~cout_w[STAGES-1];
            ovf_d  = cout_w[STAGES-1] ^ c_msb_w[STAGES-1];
        end
    end

    // Pipeline registers; reset discards every in-flight beat at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all stage registers, data included, are reset so the
        // outputs read as zero after reset, not just the valid bits.
        if (rst) begin
            stage_q <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every stage samples the pre-edge values.
            stage_q <= stage_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = stage_q[STAGES-1].valid;
    assign bus.diff      = stage_q[STAGES-1].diff_acc;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
    assign bus.zero      = stage_q[STAGES-1].zero_acc;
    assign bus.neg       = stage_q[STAGES-1].diff_acc[WIDTH-1];
`endif

    // Consumed operand slices and per-slice diagnostics that are not needed.
    assign unused_bits = ^{stage_q, c_msb_w, all_p_w};

endmodule

// File: tb/tb_pipelined_skip_subtractor.sv
// Directed bench for pipelined_skip_subtractor: reset, arithmetic corner
// cases, latency, backpressure, and reset while beats are in flight.
module tb_pipelined_skip_subtractor;
    import pipelined_skip_sub_pkg::*;

    localparam int WIDTH  = DEF_WIDTH;
    localparam int STAGES = DEF_STAGES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipelined_skip_subtractor_if #(.WIDTH(WIDTH)) bus ();

    pipelined_skip_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe; expected values are hand-computed.
    task automatic run_vec(input string name, input logic [31:0] av, input logic [31:0] bv,
                           input logic binv, input logic [31:0] ed, input logic eb, input logic eo);
        int n;
        bus.a = av;
        bus.b = bv;
        bus.bin = binv;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(STAGES));
        check({name, "_diff"}, 64'(bus.diff), 64'(ed));
        check({name, "_bout"}, 64'(bus.bout), 64'(eb));
        check({name, "_ovf"}, 64'(bus.ovf), 64'(eo));
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
        check({name, "_zero"}, 64'(bus.zero), 64'(ed == 32'h0));
        check({name, "_neg"}, 64'(bus.neg), 64'(ed[31]));
`endif
        tick();
        check({name, "_drained"}, 64'(bus.out_valid), 64'(0));
    endtask

    // Five back-to-back beats, out_ready low for 3 cycles at first result.
    task automatic backpressure_test();
        int sent = 0;
        int recvd = 0;
        int stall_left = 0;
        bit seen = 0;
        bit hs_in;
        bit hs_out;
        for (int cyc = 0; cyc < 60 && recvd < 5; cyc++) begin
            if (bus.out_valid && !seen) begin
                seen = 1;
                stall_left = 3;
            end
            bus.out_ready = (stall_left == 0);
            bus.in_valid = (sent < 5);
            bus.a = 32'(sent + 1);
            bus.b = 32'h1;
            bus.bin = 1'b0;
            #1;
            hs_in = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            if (stall_left > 0) begin
                check("bp_stall_in_ready", 64'(bus.in_ready), 64'(0));
                check("bp_stall_valid", 64'(bus.out_valid), 64'(1));
                check("bp_stall_diff", 64'(bus.diff), 64'(0));
                stall_left--;
            end
            if (hs_out) begin
                check("bp_order", 64'(bus.diff), 64'(recvd));
                recvd++;
            end
            if (hs_in) sent++;
            tick();
        end
        check("bp_seen_stall", 64'(seen), 64'(1));
        check("bp_count", 64'(recvd), 64'(5));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        // Reset held with a beat offered: nothing may enter or leave.
        bus.in_valid = 1'b1;
        bus.a = 32'h5;
        bus.b = 32'h1;
        bus.bin = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_diff", 64'(bus.diff), 64'(0));
        check("rst_bout", 64'(bus.bout), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
`ifdef PIPELINED_SKIP_SUB_FLAGS_EN
        check("rst_zero", 64'(bus.zero), 64'(0));
        check("rst_neg", 64'(bus.neg), 64'(0));
`endif
        bus.in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("idle_after_rst", 64'(bus.out_valid), 64'(0));
        end

        // Arithmetic corners.
        run_vec("borrow_wrap", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_vec("signed_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_vec("full_skip",   32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_vec("small",       32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0006, 1'b0, 1'b0);
        run_vec("pos_ovf",     32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        run_vec("equal_zero",  32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        run_vec("cross_slice", 32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0);
        run_vec("borrow_chain",32'h0000_00FF, 32'h0000_0100, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);

        backpressure_test();

        // Reset with three beats in flight: none may come out.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 32'(i + 20);
            bus.b = 32'h3;
            bus.bin = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_valid_now", 64'(bus.out_valid), 64'(0));
        tick();
        check("mid_rst_valid_edge", 64'(bus.out_valid), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mid_rst_no_stale", 64'(bus.out_valid), 64'(0));
        end

        // A held result is dropped asynchronously, between clock edges.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 32'h9;
        bus.b = 32'h2;
        bus.bin = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        check("hold_valid", 64'(bus.out_valid), 64'(1));
        check("hold_diff", 64'(bus.diff), 64'(7));
        tick();
        check("hold_diff_stable", 64'(bus.diff), 64'(7));
        check("hold_in_ready", 64'(bus.in_ready), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        check("async_drop_valid", 64'(bus.out_valid), 64'(0));
        check("async_drop_diff", 64'(bus.diff), 64'(0));
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("async_after_idle", 64'(bus.out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_skip_subtractor.md
Name: pipelined_skip_subtractor

Overview:
- Multi-cycle, pipelined WIDTH-bit subtractor: computes DIFF = A - B - BIN. Internally this is A + ~B + ~BIN.
- Built from BLOCK-bit carry-skip slices, with one slice per pipeline stage.
- Operands are skewed across stages. Input and output each use a valid/ready handshake.
- Serves as the subtract/compare datapath beside the combinational carry-skip adder in the arithmetic library.

Parameters:
WIDTH, 32, operand and result width; must be divisible by STAGES
STAGES, 4, pipeline depth and number of carry-skip slices; BLOCK = WIDTH/STAGES (localparam, default 8)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high; clears all pipeline state
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat when in_valid & in_ready
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result when out_valid & out_ready
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out; equals ~carry_out of a + ~b + ~bin
ovf  output  1  signed overflow; equals carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync release):
  - all stage valid bits, diff, bout and ovf are 0;
  - in_ready is 1 after reset.
- Pipeline structure:
  - Stage k (0..STAGES-1) computes result bits [k*BLOCK +: BLOCK] from the skewed a/b slice and the carry registered by stage k-1.
  - Stage 0 carry-in is ~bin.
  - Each slice uses carry-skip: if all BLOCK propagate bits (a_i ^ ~b_i) are 1, carry-out = carry-in (skip path); otherwise it is the ripple carry.
- Operand skew: unused upper operand slices and lower result slices are carried forward in per-stage registers. Results emerge aligned.
- Latency: exactly STAGES cycles from the accepting edge to out_valid=1 (4 cycles at default), with out_ready held high.
- Throughput: one beat per cycle when out_ready=1.
- Stall:
  - stall = out_valid & ~out_ready;
  - in_ready = ~stall;
  - on stall, every stage register (data, carry, valid) holds;
  - diff/bout/ovf stay stable while out_valid=1 and out_ready=0.
- Bubbles: a stage with valid=0 advances normally. Its data registers may update, but the outputs are don't-care while out_valid=0.
- Simultaneous input and output handshakes in one cycle are both honoured; there is no bubble insertion.
- Wrap-around: diff is modulo 2^WIDTH.
  - bout=1 iff the unsigned value a < b + bin.
  - ovf is computed from the final-stage carries only.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately (async). No stale beat is emitted after release.
- Ordering: results leave in acceptance order; none are dropped or duplicated.

Optional Feature:
- Macro PIPELINED_SKIP_SUB_FLAGS_EN.
- When defined:
  - adds output ports zero (1) and neg (1), registered with the final stage;
  - zero = (diff == 0), computed as per-stage accumulated AND of slice-zero;
  - neg = diff[WIDTH-1];
  - both reset to 0 and hold on stall exactly like diff.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package/header pipelined_skip_sub_pkg holds:
  - default WIDTH and STAGES;
  - the derived BLOCK localparam function;
  - the stage-record typedef {valid, carry, a_rem, b_rem, diff_acc, zero_acc}.
- One combinational sub-module, skip_sub_slice (BLOCK-bit):
  - inputs a, b, cin;
  - outputs d, cout, c_msb_in (carry into the slice MSB, used for ovf), all_p.
- The top level instantiates STAGES slices and owns the registers and handshake.

Test Plan:
- Reset: assert rst with in_valid=1 -> out_valid=0, diff=0, bout=0, ovf=0, in_ready=1. After release, nothing is emitted until a beat is accepted.
- Borrow wrap: a=0x00000000, b=0x00000001, bin=0, out_ready=1 -> exactly 4 cycles later diff=0xFFFFFFFF, bout=1, ovf=0.
- Signed overflow: a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, bout=0, ovf=1.
- Full skip path: a=b=0x12345678, bin=1 (all slices propagate) -> diff=0xFFFFFFFF, bout=1, ovf=0.
- Backpressure: send 5 back-to-back beats (i-1 for i=1..5 with b=1), and drop out_ready for 3 cycles once out_valid first rises.
  - in_ready=0 during the stall;
  - outputs hold 0x00000000 stable;
  - then results 0,1,2,3,4 follow in order, with none lost.
- Reset mid-flight: accept 3 beats, assert rst on the next cycle -> out_valid=0 immediately, and no result appears within 8 cycles after release.
